parity_frame_tx: RTL and testbench

PARITY_FRAME_TX -- requirements
Module: parity_frame_tx

---
 rtl/parity_frame_tx.sv | 163 ++++++++++++++++
 tb/tb_parity_frame_tx.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_frame_tx.sv
// Serial transmitter for a 16-bit word arranged as a 4x4 bit matrix.
// Frame order: start bit, 16 data bits LSB first, 4 row parities, 4 column
// parities, stop bit. An optional single-bit error can be injected into the
// transmitted data while the parity still describes the original word.
module parity_frame_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] data_in,
    input  logic        valid,
    input  logic        inject_en,
    input  logic [3:0]  inject_pos,
    output logic        ready,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        RPAR,
        CPAR,
        STOP
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [3:0]  idx, idx_nxt;
    logic [23:0] frame, frame_nxt;
    logic        tx_q, tx_nxt;
    logic        done_q, done_nxt;
    logic [3:0]  rp, cp;
    logic [15:0] inj_mask;
    logic        bit_end;

    assign inj_mask = inject_en ? (16'd1 << inject_pos) : 16'd0;
    assign bit_end  = (cnt == LAST_CNT);

    assign ready = (state == IDLE);
    assign busy  = (state != IDLE);
    assign tx    = tx_q;
    assign done  = done_q;

    // Row and column even parity of the incoming (un-injected) word
    always_comb begin
        rp = '0;
        cp = '0;
        for (int i = 0; i < 4; i++) begin
            rp[i] = ^data_in[4*i +: 4];
            cp[i] = data_in[i] ^ data_in[i+4] ^ data_in[i+8] ^ data_in[i+12];
        end
    end

    // State, counters, shift register and registered outputs; reset aborts any frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            frame  <= '0;
            tx_q   <= 1'b1;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            idx    <= idx_nxt;
            frame  <= frame_nxt;
            tx_q   <= tx_nxt;
            done_q <= done_nxt;
        end
    end

    // Next-state logic: the shift register holds {cp, rp, data}; bit 1 is the next bit to send
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 16'd1;
        idx_nxt   = idx;
        frame_nxt = frame;
        tx_nxt    = tx_q;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                idx_nxt = '0;
                tx_nxt  = 1'b1;
                if (valid) begin
                    state_nxt = START;
                    frame_nxt = {cp, rp, data_in ^ inj_mask};
                    tx_nxt    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    state_nxt = DATA;
                    tx_nxt    = frame[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_nxt   = '0;
                    tx_nxt    = frame[1];
                    frame_nxt = {1'b0, frame[23:1]};
                    if (idx == 4'd15) begin
                        idx_nxt   = '0;
                        state_nxt = RPAR;
                    end else begin
                        idx_nxt = idx + 4'd1;
                    end
                end
            end
            RPAR: begin
                if (bit_end) begin
                    cnt_nxt   = '0;
                    tx_nxt    = frame[1];
                    frame_nxt = {1'b0, frame[23:1]};
                    if (idx == 4'd3) begin
                        idx_nxt   = '0;
                        state_nxt = CPAR;
                    end else begin
                        idx_nxt = idx + 4'd1;
                    end
                end
            end
            CPAR: begin
                if (bit_end) begin
                    cnt_nxt = '0;
                    if (idx == 4'd3) begin
                        idx_nxt   = '0;
                        state_nxt = STOP;
                        tx_nxt    = 1'b1;
                    end else begin
                        idx_nxt   = idx + 4'd1;
                        tx_nxt    = frame[1];
                        frame_nxt = {1'b0, frame[23:1]};
                    end
                end
            end
            STOP: begin
                tx_nxt = 1'b1;
                if (bit_end) begin
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                idx_nxt   = '0;
                tx_nxt    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_parity_frame_tx.sv
// Scoreboard bench for parity_frame_tx: stimulus pushes expected frames,
// a monitor pops them when a start bit appears and checks every cycle.
module tb_parity_frame_tx;

    localparam int CPB          = 4;
    localparam int FRAME_BITS   = 26;
    localparam int FRAME_CYCLES = FRAME_BITS * CPB;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic [15:0] data_in    = '0;
    logic        valid      = 1'b0;
    logic        inject_en  = 1'b0;
    logic [3:0]  inject_pos = '0;
    logic        ready;
    logic        tx;
    logic        busy;
    logic        done;

    int error_count = 0;
    int check_count = 0;
    logic [25:0] exp_q[$];

    parity_frame_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .valid      (valid),
        .inject_en  (inject_en),
        .inject_pos (inject_pos),
        .ready      (ready),
        .tx         (tx),
        .busy       (busy),
        .done       (done)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Reference frame built from the bit-level rules, index 0 is sent first
    function automatic logic [25:0] model_frame(input int data, input int en, input int pos);
        logic [25:0] f;
        int word;
        int ones;
        word = (en != 0) ? (data ^ (1 << pos)) : data;
        f = '0;
        f[0] = 1'b0;
        for (int k = 0; k < 16; k++) f[1+k] = ((word >> k) & 1) != 0;
        for (int i = 0; i < 4; i++) begin
            ones = 0;
            for (int b = 0; b < 4; b++) ones += (data >> (4*i + b)) & 1;
            f[17+i] = (ones % 2) != 0;
        end
        for (int j = 0; j < 4; j++) begin
            ones = 0;
            for (int r = 0; r < 4; r++) ones += (data >> (4*r + j)) & 1;
            f[21+j] = (ones % 2) != 0;
        end
        f[25] = 1'b1;
        return f;
    endfunction

    task automatic applyStimulus(input int data, input int en, input int pos,
                                 input logic [25:0] expected, input bit hold);
        bit accepted;
        @(posedge clk);
        #1;
        data_in    = 16'(data);
        inject_en  = (en != 0);
        inject_pos = 4'(pos);
        valid      = 1'b1;
        accepted   = 1'b0;
        for (int c = 0; c < 400 && !accepted; c++) begin
            @(negedge clk);
            if (ready === 1'b1 && rst_n === 1'b1) begin
                exp_q.push_back(expected);
                accepted = 1'b1;
            end
        end
        checkOutput("acceptWithinBudget", 32'(accepted), 32'd1);
        @(posedge clk);
        #1;
        if (!hold) valid = 1'b0;
    endtask

    task automatic waitIdle();
        bit idle_seen;
        idle_seen = 1'b0;
        for (int c = 0; c < 400 && !idle_seen; c++) begin
            @(negedge clk);
            if (ready === 1'b1) idle_seen = 1'b1;
        end
        checkOutput("idleWithinBudget", 32'(idle_seen), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: detects a start bit, pops the expected frame and checks every cycle plus the done pulse
    initial begin : monitor
        logic [25:0] exp_frame;
        logic [25:0] got;
        int hold_errs;
        int ctl_errs;
        bit aborted;
        bit check_done_low;
        check_done_low = 1'b0;
        forever begin
            @(negedge clk);
            if (check_done_low) begin
                checkOutput("donePulseWidth", 32'(done), 32'd0);
                check_done_low = 1'b0;
            end
            if (rst_n === 1'b1 && tx === 1'b0) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpectedFrame", 32'd1, 32'd0);
                    for (int w = 0; w < 200 && ready !== 1'b1; w++) @(negedge clk);
                end else begin
                    exp_frame = exp_q.pop_front();
                    got       = '0;
                    hold_errs = 0;
                    ctl_errs  = 0;
                    aborted   = 1'b0;
                    for (int c = 0; c < FRAME_CYCLES; c++) begin
                        if (c > 0) @(negedge clk);
                        if (rst_n !== 1'b1) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (tx !== exp_frame[c / CPB]) hold_errs++;
                        if ((c % CPB) == (CPB / 2)) got[c / CPB] = tx;
                        if (busy !== 1'b1 || ready !== 1'b0 || done !== 1'b0) ctl_errs++;
                    end
                    if (!aborted) begin
                        checkOutput("frameBits", 32'(got), 32'(exp_frame));
                        checkOutput("bitHold", 32'(hold_errs), 32'd0);
                        checkOutput("frameCtl", 32'(ctl_errs), 32'd0);
                        @(negedge clk);
                        checkOutput("donePulse", 32'(done), 32'd1);
                        checkOutput("readyAfterStop", 32'(ready), 32'd1);
                        checkOutput("busyAfterStop", 32'(busy), 32'd0);
                        checkOutput("txIdleAfterStop", 32'(tx), 32'd1);
                        check_done_low = 1'b1;
                    end
                end
            end
        end
    end

    // Stimulus: directed frames, corner cases, then randomized traffic
    initial begin : stimulus
        int d;
        int d2;
        int en;
        int pos;
        bit got_ready;
        bit done_seen;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("resetTx", 32'(tx), 32'd1);
        checkOutput("resetReady", 32'(ready), 32'd1);
        checkOutput("resetBusy", 32'(busy), 32'd0);
        checkOutput("resetDone", 32'(done), 32'd0);

        applyStimulus(32'h0001, 0, 0, 26'h2220002, 1'b0);
        applyStimulus(32'h0001, 1, 5, 26'h2220042, 1'b0);
        applyStimulus(32'hA5C3, 0, 0, 26'h2014B86, 1'b0);

        d = int'($urandom_range(0, 65535));
        applyStimulus(d, 0, 0, model_frame(d, 0, 0), 1'b1);
        repeat (10) @(negedge clk);
        checkOutput("validIgnoredReady", 32'(ready), 32'd0);
        checkOutput("validIgnoredBusy", 32'(busy), 32'd1);
        d2  = int'($urandom_range(0, 65535));
        en  = int'($urandom_range(0, 1));
        pos = int'($urandom_range(0, 15));
        data_in    = 16'(d2);
        inject_en  = (en != 0);
        inject_pos = 4'(pos);
        got_ready  = 1'b0;
        for (int c = 0; c < 200 && !got_ready; c++) begin
            @(negedge clk);
            if (ready === 1'b1) got_ready = 1'b1;
        end
        checkOutput("reacceptSeen", 32'(got_ready), 32'd1);
        checkOutput("reacceptOnDone", 32'(done), 32'd1);
        exp_q.push_back(model_frame(d2, en, pos));
        @(posedge clk);
        #1;
        valid = 1'b0;
        @(negedge clk);
        checkOutput("backToBackStart", 32'(tx), 32'd0);
        checkOutput("backToBackBusy", 32'(busy), 32'd1);

        d = int'($urandom_range(0, 65535));
        applyStimulus(d, 0, 0, model_frame(d, 0, 0), 1'b0);
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("abortTx", 32'(tx), 32'd1);
        checkOutput("abortReady", 32'(ready), 32'd1);
        checkOutput("abortBusy", 32'(busy), 32'd0);
        done_seen = 1'b0;
        for (int c = 0; c < 150; c++) begin
            if (done === 1'b1) done_seen = 1'b1;
            @(negedge clk);
        end
        checkOutput("noDoneAfterAbort", 32'(done_seen), 32'd0);

        d   = int'($urandom_range(0, 65535));
        pos = int'($urandom_range(0, 15));
        applyStimulus(d, 1, pos, model_frame(d, 1, pos), 1'b0);
        waitIdle();

        @(posedge clk);
        #1;
        rst_n   = 1'b0;
        valid   = 1'b1;
        data_in = 16'($urandom_range(0, 65535));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        valid = 1'b0;
        @(negedge clk);
        checkOutput("resetValidTx", 32'(tx), 32'd1);
        checkOutput("resetValidBusy", 32'(busy), 32'd0);
        checkOutput("resetValidReady", 32'(ready), 32'd1);
        repeat (5) @(negedge clk);

        for (int n = 0; n < 10; n++) begin
            d   = int'($urandom_range(0, 65535));
            en  = int'($urandom_range(0, 1));
            pos = int'($urandom_range(0, 15));
            applyStimulus(d, en, pos, model_frame(d, en, pos), 1'b0);
        end
        waitIdle();
        repeat (3) @(negedge clk);
        checkOutput("queueDrained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

    // Watchdog so a stuck design cannot hang the run
    initial begin : watchdog
        #300000;
        $display("[TB] FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
